// File: rtl/alu_muldiv.sv
// Registered ALU with RV32M multiply/divide and valid/ready handshakes on both sides.
// One op in flight; base ops finish in one cycle, iterative mul/div take XLEN more.
module alu_muldiv #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FAST_MUL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic            a_sel,
  input  logic            b_sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned SW = $clog2(XLEN);

  localparam logic [4:0] OpAdd = 5'd0,  OpSub = 5'd1,  OpAnd = 5'd2,  OpOr = 5'd3;
  localparam logic [4:0] OpXor = 5'd4,  OpSll = 5'd5,  OpSrl = 5'd6,  OpSra = 5'd7;
  localparam logic [4:0] OpLui = 5'd8,  OpSlt = 5'd9,  OpSltu = 5'd10, OpMul = 5'd11;
  localparam logic [4:0] OpMulh = 5'd12, OpMulhsu = 5'd13, OpMulhu = 5'd14, OpDiv = 5'd15;
  localparam logic [4:0] OpDivu = 5'd16, OpRem = 5'd17, OpRemu = 5'd18;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [XLEN-1:0]   r_result, w_result_d;
  logic [2*XLEN-1:0] r_acc, w_acc_d;
  logic [XLEN-1:0]   r_mag, w_mag_d;
  logic [SW-1:0]     r_cnt, w_cnt_d;
  logic [4:0]        r_op, w_op_d;
  logic              r_neg_q, w_neg_q_d;
  logic              r_neg_r, w_neg_r_d;

  logic [XLEN-1:0]   w_a, w_b, w_a_mag, w_b_mag, w_alu, w_special;
  logic [SW-1:0]     w_sh;
  logic              w_accept, w_is_mul, w_is_div, w_div_signed, w_is_quot;
  logic              w_a_sgn, w_b_sgn, w_div_zero, w_div_ovf;
  logic [2*XLEN-1:0] w_pa, w_pb, w_prod;
  logic [XLEN:0]     w_mul_sum, w_div_rem_sh, w_div_diff;
  logic [2*XLEN-1:0] w_mul_step, w_div_step, w_prod_fix;
  logic [XLEN-1:0]   w_mul_res, w_div_res, w_quo, w_rem;

  assign w_a  = a_sel ? rs1 : pc;
  assign w_b  = b_sel ? imm : rs2;
  assign w_sh = w_b[SW-1:0];

  assign in_ready  = !flush && (r_state == StIdle || (r_state == StDone && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == StDone);
  assign result    = r_result;

  assign w_is_mul     = (op >= OpMul) && (op <= OpMulhu);
  assign w_is_div     = (op >= OpDiv) && (op <= OpRemu);
  assign w_div_signed = (op == OpDiv) || (op == OpRem);
  assign w_is_quot    = (op == OpDiv) || (op == OpDivu);

  // Operand signs only count for the signed flavours; magnitudes feed the iterative units.
  assign w_a_sgn = w_a[XLEN-1] & ((op == OpMul) | (op == OpMulh) | (op == OpMulhsu) | w_div_signed);
  assign w_b_sgn = w_b[XLEN-1] & ((op == OpMul) | (op == OpMulh) | w_div_signed);
  assign w_a_mag = w_a_sgn ? -w_a : w_a;
  assign w_b_mag = w_b_sgn ? -w_b : w_b;

  assign w_div_zero = (w_b == '0);
  assign w_div_ovf  = w_div_signed && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);
  assign w_special  = w_div_zero ? (w_is_quot ? '1 : w_a) : (w_is_quot ? w_a : '0);

  // Low 2*XLEN bits of the sign-extended product cover all four multiply flavours.
  assign w_pa   = {{XLEN{w_a_sgn}}, w_a};
  assign w_pb   = {{XLEN{w_b_sgn}}, w_b};
  assign w_prod = w_pa * w_pb;

  always_comb begin
    w_alu = '0;
    case (op)
      OpAdd:    w_alu = w_a + w_b;
      OpSub:    w_alu = w_a - w_b;
      OpAnd:    w_alu = w_a & w_b;
      OpOr:     w_alu = w_a | w_b;
      OpXor:    w_alu = w_a ^ w_b;
      OpSll:    w_alu = w_a << w_sh;
      OpSrl:    w_alu = w_a >> w_sh;
      OpSra:    w_alu = $signed(w_a) >>> w_sh;
      OpLui:    w_alu = w_b;
      OpSlt:    w_alu = XLEN'($signed(w_a) < $signed(w_b));
      OpSltu:   w_alu = XLEN'(w_a < w_b);
      OpMul:    w_alu = w_prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_alu = w_prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu, OpRem, OpRemu: w_alu = w_special;
      default:  w_alu = '0;
    endcase
  end

  // r_acc = {partial product, multiplier} during MUL, {remainder, quotient} during DIV.
  assign w_mul_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mag};
  assign w_mul_step   = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
  assign w_div_rem_sh = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff   = w_div_rem_sh - {1'b0, r_mag};
  assign w_div_step   = w_div_diff[XLEN] ? {w_div_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? -w_mul_step : w_mul_step;
  assign w_mul_res  = (r_op == OpMul) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
  assign w_quo      = w_div_step[XLEN-1:0];
  assign w_rem      = w_div_step[2*XLEN-1:XLEN];
  assign w_div_res  = ((r_op == OpDiv) || (r_op == OpDivu)) ? (r_neg_q ? -w_quo : w_quo)
                                                            : (r_neg_r ? -w_rem : w_rem);

  always_comb begin
    w_state_d  = r_state;
    w_result_d = r_result;
    w_acc_d    = r_acc;
    w_mag_d    = r_mag;
    w_cnt_d    = r_cnt;
    w_op_d     = r_op;
    w_neg_q_d  = r_neg_q;
    w_neg_r_d  = r_neg_r;
    if (flush) begin
      w_state_d = StIdle;
    end else if (w_accept) begin
      w_op_d    = op;
      w_cnt_d   = '0;
      w_neg_q_d = w_a_sgn ^ w_b_sgn;
      w_neg_r_d = w_a_sgn;
      if (w_is_mul && FAST_MUL == 0) begin
        w_state_d = StMul;
        w_acc_d   = {{XLEN{1'b0}}, w_b_mag};
        w_mag_d   = w_a_mag;
      end else if (w_is_div && !w_div_zero && !w_div_ovf) begin
        w_state_d = StDiv;
        w_acc_d   = {{XLEN{1'b0}}, w_a_mag};
        w_mag_d   = w_b_mag;
      end else begin
        w_state_d  = StDone;
        w_result_d = w_alu;
      end
    end else begin
      case (r_state)
        StMul: begin
          w_acc_d = w_mul_step;
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt == '1) begin
            w_state_d  = StDone;
            w_result_d = w_mul_res;
          end
        end
        StDiv: begin
          w_acc_d = w_div_step;
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt == '1) begin
            w_state_d  = StDone;
            w_result_d = w_div_res;
          end
        end
        StDone: if (out_ready) w_state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_result <= '0;
      r_acc    <= '0;
      r_mag    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_result <= w_result_d;
      r_acc    <= w_acc_d;
      r_mag    <= w_mag_d;
      r_cnt    <= w_cnt_d;
      r_op     <= w_op_d;
      r_neg_q  <= w_neg_q_d;
      r_neg_r  <= w_neg_r_d;
    end
  end

endmodule
